// File: rtl/fir_transposed_param_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg : shared definitions for the transposed-form FIR block.
//
// Contents
//   fir_clog2      - ceiling log2, used for address width and accumulator growth
//   fir_acc_w      - full-precision accumulator width DATA_W + COEF_W + clog2(TAPS)
//   fir_round_sat  - round-half-up, arithmetic shift and saturate to a sample
//                    width; returns the result on a 64-bit signed carrier and
//                    reports saturation through an output argument
//   sample_t / coef_t - signed sample and coefficient types at default widths
//
// Optional feature macro used by the top level: FIR_ROUND_SAT_EN
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  // Carrier width for the round/saturate helper; accumulators must fit in it.
  localparam int RS_W       = 64;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;
  typedef logic signed [DEF_COEF_W-1:0] coef_t;

  function automatic int fir_clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int fir_acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + fir_clog2(taps);
  endfunction

  // One extra bit of headroom keeps the rounding bias from wrapping.
  function automatic logic signed [RS_W-1:0] fir_round_sat(
    input  logic signed [RS_W-1:0] acc,
    input  int                     shift,
    input  int                     data_w,
    output logic                   sat
  );
    logic signed [RS_W:0] t;
    logic signed [RS_W:0] max_v;
    logic signed [RS_W:0] min_v;
    logic signed [RS_W-1:0] res;
    t = {acc[RS_W-1], acc};
    if (shift > 0) begin
      t = t + ((RS_W+1)'(1) <<< (shift - 1));
    end else begin
      t = t;
    end
    t     = t >>> shift;
    max_v = ((RS_W+1)'(1) <<< (data_w - 1)) - (RS_W+1)'(1);
    min_v = -((RS_W+1)'(1) <<< (data_w - 1));
    if (t > max_v) begin
      sat = 1'b1;
      res = max_v[RS_W-1:0];
    end else if (t < min_v) begin
      sat = 1'b1;
      res = min_v[RS_W-1:0];
    end else begin
      sat = 1'b0;
      res = t[RS_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_transposed_param_if.sv
// -----------------------------------------------------------------------------
// fir_transposed_param_if : sample, coefficient and result bus of the FIR.
//
// Signals (directions seen from the FIR, i.e. the slave modport)
//   iEnSample_300k in   sample strobe, 1-cycle pulse
//   iFirIn         in   signed input sample
//   iCascadeIn     in   signed partial sum from an upstream block (ACC_W)
//   iClear         in   flush partial sums
//   iCoefWr        in   shadow-bank write enable
//   iCoefAddr      in   tap index (AW bits)
//   iCoefData      in   signed coefficient
//   iCoefCommit    in   request shadow-to-active swap
//   oCoefPending   out  swap requested but not yet applied
//   oFirOut        out  signed scaled output
//   oValid         out  1-cycle pulse on output update
//   oCascadeOut    out  full-precision accumulator (ACC_W)
//   oOvf           out  sticky saturation flag
// -----------------------------------------------------------------------------
interface fir_transposed_param_if #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int TAPS   = 4
) ();
  import fir_pkg::*;

  localparam int AW    = fir_clog2(TAPS);
  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, TAPS);

  logic                     iEnSample_300k;
  logic signed [DATA_W-1:0] iFirIn;
  logic signed [ACC_W-1:0]  iCascadeIn;
  logic                     iClear;
  logic                     iCoefWr;
  logic [AW-1:0]            iCoefAddr;
  logic signed [COEF_W-1:0] iCoefData;
  logic                     iCoefCommit;
  logic                     oCoefPending;
  logic signed [DATA_W-1:0] oFirOut;
  logic                     oValid;
  logic signed [ACC_W-1:0]  oCascadeOut;
  logic                     oOvf;

  modport master (
    output iEnSample_300k, iFirIn, iCascadeIn, iClear,
    output iCoefWr, iCoefAddr, iCoefData, iCoefCommit,
    input  oCoefPending, oFirOut, oValid, oCascadeOut, oOvf
  );

  modport slave (
    input  iEnSample_300k, iFirIn, iCascadeIn, iClear,
    input  iCoefWr, iCoefAddr, iCoefData, iCoefCommit,
    output oCoefPending, oFirOut, oValid, oCascadeOut, oOvf
  );

endinterface

// File: rtl/fir_transposed_param_tap.sv
// -----------------------------------------------------------------------------
// fir_tap : one multiply-add-register stage of the transposed FIR.
//
// Ports
//   iClk, iRst  clock, synchronous active-high reset
//   iEn         sample strobe; the register loads only when high
//   iClear      zero the register (wins over iEn)
//   iX, iC      signed sample and coefficient
//   iPartIn     partial sum from the next-higher stage (or cascade input)
//   oSumNext    x*c + iPartIn, the value loaded on the next strobe
//   oPartOut    registered partial sum
// -----------------------------------------------------------------------------
module fir_tap #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iEn,
  input  logic                     iClear,
  input  logic signed [DATA_W-1:0] iX,
  input  logic signed [COEF_W-1:0] iC,
  input  logic signed [ACC_W-1:0]  iPartIn,
  output logic signed [ACC_W-1:0]  oSumNext,
  output logic signed [ACC_W-1:0]  oPartOut
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  r_part;

  // Full-precision product, sign-extended to the accumulator width.
  assign w_prod     = PROD_W'(iX) * PROD_W'(iC);
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign oSumNext   = w_prod_ext + iPartIn;
  assign oPartOut   = r_part;

  // Partial-sum register: reset, then clear, then strobe load.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_part <= '0;
    end else if (iClear) begin
      r_part <= '0;
    end else if (iEn) begin
      r_part <= oSumNext;
    end else begin
      r_part <= r_part;
    end
  end

endmodule

// File: rtl/fir_transposed_param.sv
// -----------------------------------------------------------------------------
// fir_transposed_param : N-tap transposed-form FIR with double-buffered
// coefficients, cascade chaining and configurable output scaling.
//
// Ports
//   iClk_12M  system clock
//   iRst      synchronous active-high reset
//   bus       fir_transposed_param_if.slave (strobe, sample, cascade, clear,
//             coefficient write/commit, outputs)
//
// Optional feature macro: FIR_ROUND_SAT_EN
//   defined   - output is round-half-up, shifted, saturated; oOvf is sticky
//   undefined - output is a plain bit slice of the accumulator; oOvf stays 0
// -----------------------------------------------------------------------------
module fir_transposed_param
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 4,
  parameter int OUT_SHIFT = 15
) (
  input logic                    iClk_12M,
  input logic                    iRst,
  fir_transposed_param_if.slave  bus
);

  localparam int AW    = fir_clog2(TAPS);
  localparam int ACC_W = fir_acc_w(DATA_W, COEF_W, TAPS);

  logic signed [COEF_W-1:0] r_coef_act    [0:TAPS-1];
  logic signed [COEF_W-1:0] r_coef_shadow [0:TAPS-1];
  logic signed [COEF_W-1:0] w_shadow_next [0:TAPS-1];
  logic signed [COEF_W-1:0] w_coef_use    [0:TAPS-1];
  logic                     r_pending;

  logic                     w_addr_ok;
  logic                     w_strobe;
  logic                     w_swap;

  // w_part[TAPS] is the cascade input; w_part[0] is the accumulator.
  logic signed [ACC_W-1:0]  w_part     [0:TAPS];
  logic signed [ACC_W-1:0]  w_sum_next [0:TAPS-1];
  logic signed [ACC_W-1:0]  w_acc_next;

  logic signed [DATA_W-1:0] w_fir_next;
  logic                     w_sat;
  logic signed [DATA_W-1:0] r_fir_out;
  logic                     r_valid;
  logic                     r_ovf;

  assign w_addr_ok  = ({{(32-AW){1'b0}}, bus.iCoefAddr} < 32'(TAPS));
  // A strobe coinciding with iClear is dropped entirely.
  assign w_strobe   = bus.iEnSample_300k & ~bus.iClear;
  // A commit in the same cycle as the strobe already takes effect.
  assign w_swap     = w_strobe & (r_pending | bus.iCoefCommit);
  assign w_part[TAPS] = bus.iCascadeIn;
  assign w_acc_next = w_sum_next[0];

  // Shadow bank including this cycle's write, so write+commit swaps it in.
  always_comb begin
    w_shadow_next = r_coef_shadow;
    if (bus.iCoefWr && w_addr_ok) begin
      w_shadow_next[bus.iCoefAddr] = bus.iCoefData;
    end else begin
      w_shadow_next = r_coef_shadow;
    end
  end

  // Coefficients seen by the taps: the swapping strobe uses the new set.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      if (w_swap) begin
        w_coef_use[k] = w_shadow_next[k];
      end else begin
        w_coef_use[k] = r_coef_act[k];
      end
    end
  end

  // Coefficient banks and swap-pending flag.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      for (int k = 0; k < TAPS; k++) begin
        r_coef_act[k]    <= '0;
        r_coef_shadow[k] <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      r_coef_shadow <= w_shadow_next;
      if (w_swap) begin
        r_coef_act <= w_shadow_next;
        r_pending  <= 1'b0;
      end else if (bus.iCoefCommit) begin
        r_coef_act <= r_coef_act;
        r_pending  <= 1'b1;
      end else begin
        r_coef_act <= r_coef_act;
        r_pending  <= r_pending;
      end
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .iClk     (iClk_12M),
      .iRst     (iRst),
      .iEn      (bus.iEnSample_300k),
      .iClear   (bus.iClear),
      .iX       (bus.iFirIn),
      .iC       (w_coef_use[k]),
      .iPartIn  (w_part[k+1]),
      .oSumNext (w_sum_next[k]),
      .oPartOut (w_part[k])
    );
  end

`ifdef FIR_ROUND_SAT_EN
  logic signed [RS_W-1:0] w_acc_wide;
  logic signed [RS_W-1:0] w_rs_wide;

  // Scaled output with rounding and saturation, computed from the next acc.
  always_comb begin
    w_acc_wide = {{(RS_W-ACC_W){w_acc_next[ACC_W-1]}}, w_acc_next};
    w_sat      = 1'b0;
    w_rs_wide  = fir_round_sat(w_acc_wide, OUT_SHIFT, DATA_W, w_sat);
    w_fir_next = w_rs_wide[DATA_W-1:0];
  end
`else
  // Scaled output as a wrapping bit slice of the next acc.
  always_comb begin
    w_fir_next = w_acc_next[OUT_SHIFT+DATA_W-1:OUT_SHIFT];
    w_sat      = 1'b0;
  end
`endif

  // Output register, valid pulse and sticky overflow flag.
  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      r_fir_out <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (bus.iClear) begin
      r_fir_out <= '0;
      r_valid   <= 1'b0;
      r_ovf     <= r_ovf;
    end else if (bus.iEnSample_300k) begin
      r_fir_out <= w_fir_next;
      r_valid   <= 1'b1;
      r_ovf     <= r_ovf | w_sat;
    end else begin
      r_fir_out <= r_fir_out;
      r_valid   <= 1'b0;
      r_ovf     <= r_ovf;
    end
  end

  assign bus.oFirOut      = r_fir_out;
  assign bus.oValid       = r_valid;
  assign bus.oOvf         = r_ovf;
  assign bus.oCascadeOut  = w_part[0];
  assign bus.oCoefPending = r_pending;

endmodule

// File: tb/tb_fir_transposed_param.sv
// -----------------------------------------------------------------------------
// tb_fir_transposed_param : directed self-checking bench for the 4-tap FIR
// built with OUT_SHIFT = 0. Expected values are hand-computed from the
// transposed-form recurrence.
// -----------------------------------------------------------------------------
module tb_fir_transposed_param;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TP = 4;

`ifdef FIR_ROUND_SAT_EN
  localparam int EXP_SAT_OUT = 32767;
  localparam int EXP_SAT_OVF = 1;
`else
  localparam int EXP_SAT_OUT = 1;
  localparam int EXP_SAT_OVF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fir_transposed_param_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(TP)) bus ();

  fir_transposed_param #(
    .DATA_W    (DW),
    .COEF_W    (CW),
    .TAPS      (TP),
    .OUT_SHIFT (0)
  ) dut (
    .iClk_12M (clk),
    .iRst     (rst),
    .bus      (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wr(input int addr, input int data, input logic commit);
    bus.iCoefWr     = 1'b1;
    bus.iCoefAddr   = addr[1:0];
    bus.iCoefData   = data[15:0];
    bus.iCoefCommit = commit;
    step();
    bus.iCoefWr     = 1'b0;
    bus.iCoefCommit = 1'b0;
  endtask

  // One strobe, then one idle cycle checking that the output holds.
  task automatic sample(input string tag, input int x, input logic commit, input int expv);
    sample_t xs;
    xs = x[15:0];
    bus.iEnSample_300k = 1'b1;
    bus.iFirIn         = xs;
    bus.iCoefCommit    = commit;
    step();
    chk({tag, " valid"}, bus.oValid, 1);
    chk({tag, " out"}, bus.oFirOut, expv);
    chk({tag, " pend"}, bus.oCoefPending, 0);
    bus.iEnSample_300k = 1'b0;
    bus.iFirIn         = '0;
    bus.iCoefCommit    = 1'b0;
    step();
    chk({tag, " hold valid"}, bus.oValid, 0);
    chk({tag, " hold out"}, bus.oFirOut, expv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.iEnSample_300k = 1'b0;
    bus.iFirIn         = '0;
    bus.iCascadeIn     = '0;
    bus.iClear         = 1'b0;
    bus.iCoefWr        = 1'b0;
    bus.iCoefAddr      = '0;
    bus.iCoefData      = '0;
    bus.iCoefCommit    = 1'b0;
    step();
    step();
    chk("rst out", bus.oFirOut, 0);
    chk("rst casc", bus.oCascadeOut, 0);
    chk("rst valid", bus.oValid, 0);
    chk("rst pend", bus.oCoefPending, 0);
    chk("rst ovf", bus.oOvf, 0);
    rst = 1'b0;

    // 1: impulse through {1,2,3,4}
    wr(0, 1, 1'b0);
    wr(1, 2, 1'b0);
    wr(2, 3, 1'b0);
    wr(3, 4, 1'b0);
    chk("t1 pend before commit", bus.oCoefPending, 0);
    bus.iCoefCommit = 1'b1;
    step();
    bus.iCoefCommit = 1'b0;
    chk("t1 pend set", bus.oCoefPending, 1);
    step();
    chk("t1 pend held", bus.oCoefPending, 1);
    sample("t1 s0", 100, 1'b0, 100);
    bus.iEnSample_300k = 1'b1;
    bus.iFirIn         = '0;
    step();
    chk("t1 b2b1 valid", bus.oValid, 1);
    chk("t1 b2b1 out", bus.oFirOut, 200);
    step();
    chk("t1 b2b2 valid", bus.oValid, 1);
    chk("t1 b2b2 out", bus.oFirOut, 300);
    bus.iEnSample_300k = 1'b0;
    step();
    chk("t1 b2b idle valid", bus.oValid, 0);
    chk("t1 b2b idle out", bus.oFirOut, 300);
    sample("t1 s3", 0, 1'b0, 400);
    sample("t1 s4", 0, 1'b0, 0);

    // 2: commit coincident with a strobe, new set {4,3,2,1}
    wr(0, 4, 1'b0);
    wr(1, 3, 1'b0);
    wr(2, 2, 1'b0);
    wr(3, 1, 1'b0);
    chk("t2 pend", bus.oCoefPending, 0);
    sample("t2 old", 100, 1'b0, 100);
    sample("t2 swap", 10, 1'b1, 240);
    sample("t2 s2", 0, 1'b0, 330);
    sample("t2 s3", 0, 1'b0, 420);
    sample("t2 s4", 0, 1'b0, 10);
    sample("t2 s5", 0, 1'b0, 0);
    sample("t2 neg0", -7, 1'b0, -28);
    sample("t2 neg1", 0, 1'b0, -21);
    sample("t2 neg2", 0, 1'b0, -14);
    sample("t2 neg3", 0, 1'b0, -7);
    sample("t2 neg4", 0, 1'b0, 0);

    // 3: cascade input reaches the output after TAPS strobes
    bus.iCascadeIn = 34'sd1000;
    for (int i = 0; i < 4; i++) begin
      sample("t3 fill", 0, 1'b0, (i == 3) ? 1000 : 0);
      chk("t3 fill casc", bus.oCascadeOut, (i == 3) ? 1000 : 0);
    end
    bus.iCascadeIn = '0;
    for (int i = 0; i < 4; i++) begin
      sample("t3 drain", 0, 1'b0, (i == 3) ? 0 : 1000);
    end

    // 5: clear coincident with a strobe; write+commit same cycle
    wr(0, 1, 1'b0);
    wr(1, 2, 1'b0);
    wr(2, 3, 1'b0);
    wr(3, 4, 1'b1);
    chk("t5 pend wr+commit", bus.oCoefPending, 1);
    sample("t5 a", 100, 1'b0, 100);
    sample("t5 b", 0, 1'b0, 200);
    bus.iCoefCommit = 1'b1;
    step();
    bus.iCoefCommit = 1'b0;
    chk("t5 pend pre clear", bus.oCoefPending, 1);
    bus.iClear         = 1'b1;
    bus.iEnSample_300k = 1'b1;
    bus.iFirIn         = 16'sd55;
    step();
    chk("t5 clr valid", bus.oValid, 0);
    chk("t5 clr out", bus.oFirOut, 0);
    chk("t5 clr casc", bus.oCascadeOut, 0);
    chk("t5 clr pend", bus.oCoefPending, 1);
    bus.iClear         = 1'b0;
    bus.iEnSample_300k = 1'b0;
    bus.iFirIn         = '0;
    step();
    chk("t5 post valid", bus.oValid, 0);
    chk("t5 post out", bus.oFirOut, 0);
    sample("t5 r0", 100, 1'b0, 100);
    sample("t5 r1", 0, 1'b0, 200);
    sample("t5 r2", 0, 1'b0, 300);
    sample("t5 r3", 0, 1'b0, 400);
    sample("t5 r4", 0, 1'b0, 0);

    // 4: full-scale coefficients and sample
    wr(0, 32767, 1'b0);
    wr(1, 32767, 1'b0);
    wr(2, 32767, 1'b0);
    wr(3, 32767, 1'b1);
    chk("t4 ovf before", bus.oOvf, 0);
    sample("t4 sat", 32767, 1'b0, EXP_SAT_OUT);
    chk("t4 casc", bus.oCascadeOut, 1073676289);
    chk("t4 ovf", bus.oOvf, EXP_SAT_OVF);
    bus.iClear = 1'b1;
    step();
    bus.iClear = 1'b0;
    chk("t4 clr out", bus.oFirOut, 0);
    chk("t4 ovf sticky clr", bus.oOvf, EXP_SAT_OVF);
    sample("t4 z", 0, 1'b0, 0);
    chk("t4 ovf sticky", bus.oOvf, EXP_SAT_OVF);

    // 6: reset mid-stream with a pending swap
    sample("t6 pre", 1, 1'b0, 32767);
    wr(0, 5, 1'b1);
    chk("t6 pend", bus.oCoefPending, 1);
    rst                = 1'b1;
    bus.iEnSample_300k = 1'b1;
    bus.iFirIn         = 16'sd100;
    step();
    chk("t6 rst out", bus.oFirOut, 0);
    chk("t6 rst casc", bus.oCascadeOut, 0);
    chk("t6 rst valid", bus.oValid, 0);
    chk("t6 rst pend", bus.oCoefPending, 0);
    chk("t6 rst ovf", bus.oOvf, 0);
    rst                = 1'b0;
    bus.iEnSample_300k = 1'b0;
    bus.iFirIn         = '0;
    step();
    sample("t6 post0", 100, 1'b0, 0);
    sample("t6 post1", 0, 1'b0, 0);
    sample("t6 post2", 0, 1'b0, 0);
    sample("t6 post3", 0, 1'b0, 0);
    chk("t6 post casc", bus.oCascadeOut, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
